// File: rtl/mux_arbiter.sv
// Registered two-source arbiter feeding a 2:1 datapath mux and one output register.
// Define MUX_ARB_RR_EN for round-robin arbitration with BURST limit; otherwise x has fixed priority.
module mux_arbiter #(
  parameter int unsigned W     = 64,
  parameter int unsigned BURST = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] x,
  input  logic         x_req,
  output logic         x_ack,
  input  logic [W-1:0] y,
  input  logic         y_req,
  output logic         y_ack,
  output logic         s,
  output logic [W-1:0] d,
  output logic         d_valid,
  input  logic         d_ready
);

  if (BURST < 1 || BURST > 15) begin : g_bad_burst
    $error("mux_arbiter: BURST must be in 1..15");
  end

  logic free;
  logic gx;
  logic gy;
  logic ack;

  assign free  = !d_valid || d_ready;
  assign x_ack = gx && free && !rst;
  assign y_ack = gy && free && !rst;
  assign ack   = x_ack || y_ack;

`ifdef MUX_ARB_RR_EN
  typedef enum logic [1:0] {IDLE, OWN_X, OWN_Y} state_t;

  localparam logic [3:0] BURST_L = 4'(BURST);

  state_t     state;
  state_t     state_nx;
  logic [3:0] cnt;
  logic [3:0] cnt_nx;
  logic       lg;
  logic       lg_nx;

  // lg holds the last granted source (1 = y), so an IDLE tie goes to the other one.
  always_comb begin
    gx = 1'b0;
    gy = 1'b0;
    unique case (state)
      IDLE: begin
        if (x_req && y_req) begin
          gx = lg;
          gy = !lg;
        end else begin
          gx = x_req;
          gy = y_req;
        end
      end
      OWN_X: begin
        if (x_req && (!y_req || cnt < BURST_L)) gx = 1'b1;
        else                                    gy = y_req;
      end
      OWN_Y: begin
        if (y_req && (!x_req || cnt < BURST_L)) gy = 1'b1;
        else                                    gx = x_req;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    lg_nx    = lg;
    if (free) begin
      if (gx || gy) begin
        state_nx = gy ? OWN_Y : OWN_X;
        lg_nx    = gy;
        if (state_nx == state) cnt_nx = (cnt == 4'd15) ? cnt : cnt + 4'd1;
        else                   cnt_nx = 4'd1;
      end else begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      lg    <= 1'b1;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      lg    <= lg_nx;
    end
  end
`else
  always_comb begin
    gx = x_req;
    gy = !x_req && y_req;
  end
`endif

  // Delivery and reload share the same edge when d_ready is high, so there is no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      d       <= '0;
      d_valid <= 1'b0;
      s       <= 1'b0;
    end else if (free) begin
      if (ack) begin
        d       <= y_ack ? y : x;
        d_valid <= 1'b1;
        s       <= y_ack;
      end else begin
        d_valid <= 1'b0;
      end
    end
  end

endmodule
